// File: rtl/erm16_bus_pkg.sv
// Shared types and default constants for the ERM16 bus interface unit.
package erm16_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_ACC = 2'd1,
    IO_ACC  = 2'd2,
    RESP    = 2'd3
  } bus_state_t;

  localparam int unsigned DEF_MEM_WAIT   = 1;
  localparam int unsigned DEF_IO_TIMEOUT = 15;
  localparam logic [15:0] DEF_ERR_DATA   = 16'hFFFF;
  localparam int unsigned IO_AW          = 8;

endpackage

// File: rtl/bus_wait_timer.sv
// 8-bit loadable down-counter shared by the memory wait and I/O timeout paths.
module bus_wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] value,
  output logic [7:0] count,
  output logic       zero
);

  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else if (load) begin
      count_q <= value;
    end else if (dec && (count_q != 8'd0)) begin
      count_q <= count_q - 8'd1;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == 8'd0);

endmodule

// File: rtl/erm16_bus_interface.sv
// Routes ERM16 core accesses to the memory or I/O port, with wait states and I/O timeout.
module erm16_bus_interface
  import erm16_bus_pkg::*;
#(
  parameter int unsigned MEM_WAIT   = DEF_MEM_WAIT,
  parameter int unsigned IO_TIMEOUT = DEF_IO_TIMEOUT,
  parameter logic [15:0] ERR_DATA   = DEF_ERR_DATA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic [15:0]      cpu_addr,
  input  logic [15:0]      cpu_do,
  input  logic             cpu_wrmem,
  input  logic             cpu_ioe,
  output logic [15:0]      cpu_di,
  output logic             cpu_ready,
  output logic             bus_err,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  output logic             mem_re,
  output logic             mem_we,
  input  logic [15:0]      mem_rdata,
  output logic [IO_AW-1:0] io_addr,
  output logic [15:0]      io_wdata,
  output logic             io_rd,
  output logic             io_wr,
  input  logic [15:0]      io_rdata,
  input  logic             io_ack
);

  localparam logic [7:0] MemWaitLd   = 8'(MEM_WAIT);
  localparam logic [7:0] IoTimeoutLd = 8'(IO_TIMEOUT);

  bus_state_t       state_q, state_d;
  logic             wr_q, wr_d;
  logic             err_q, err_d;
  logic [15:0]      cpu_di_q, cpu_di_d;
  logic             ready_q, ready_d;
  logic             bus_err_q, bus_err_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic [15:0]      mem_wdata_q, mem_wdata_d;
  logic             mem_re_q, mem_re_d;
  logic             mem_we_q, mem_we_d;
  logic [IO_AW-1:0] io_addr_q, io_addr_d;
  logic [15:0]      io_wdata_q, io_wdata_d;
  logic             io_rd_q, io_rd_d;
  logic             io_wr_q, io_wr_d;

  logic       tmr_load, tmr_dec, tmr_zero;
  logic [7:0] tmr_value, tmr_count;

  bus_wait_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .dec   (tmr_dec),
    .value (tmr_value),
    .count (tmr_count),
    .zero  (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    err_d       = err_q;
    cpu_di_d    = cpu_di_q;
    ready_d     = 1'b0;
    bus_err_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    io_addr_d   = io_addr_q;
    io_wdata_d  = io_wdata_q;
    io_rd_d     = io_rd_q;
    io_wr_d     = io_wr_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    tmr_value   = 8'd0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          wr_d        = cpu_wrmem;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_do;
          io_addr_d   = cpu_addr[IO_AW-1:0];
          io_wdata_d  = cpu_do;
          tmr_load    = 1'b1;
          if (!cpu_ioe) begin
            state_d   = MEM_ACC;
            mem_re_d  = !cpu_wrmem;
            mem_we_d  = cpu_wrmem;
            tmr_value = MemWaitLd;
          end else begin
            state_d   = IO_ACC;
            io_rd_d   = !cpu_wrmem;
            io_wr_d   = cpu_wrmem;
            tmr_value = IoTimeoutLd;
          end
        end
      end
      MEM_ACC: begin
        if (tmr_zero) begin
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          err_d    = 1'b0;
          if (!wr_q) cpu_di_d = mem_rdata;
          state_d  = RESP;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      IO_ACC: begin
        // Acknowledge wins over a timeout falling in the same cycle.
        if (io_ack) begin
          io_rd_d = 1'b0;
          io_wr_d = 1'b0;
          err_d   = 1'b0;
          if (!wr_q) cpu_di_d = io_rdata;
          state_d = RESP;
        end else if (tmr_count == 8'd1) begin
          io_rd_d = 1'b0;
          io_wr_d = 1'b0;
          err_d   = 1'b1;
          if (!wr_q) cpu_di_d = ERR_DATA;
          state_d = RESP;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      RESP: begin
        ready_d   = 1'b1;
        bus_err_d = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      cpu_di_q    <= 16'd0;
      ready_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 16'd0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      io_addr_q   <= '0;
      io_wdata_q  <= 16'd0;
      io_rd_q     <= 1'b0;
      io_wr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      err_q       <= err_d;
      cpu_di_q    <= cpu_di_d;
      ready_q     <= ready_d;
      bus_err_q   <= bus_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      io_addr_q   <= io_addr_d;
      io_wdata_q  <= io_wdata_d;
      io_rd_q     <= io_rd_d;
      io_wr_q     <= io_wr_d;
    end
  end

  assign cpu_di    = cpu_di_q;
  assign cpu_ready = ready_q;
  assign bus_err   = bus_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = io_wdata_q;
  assign io_rd     = io_rd_q;
  assign io_wr     = io_wr_q;

endmodule

// File: tb/tb_erm16_bus_interface.sv
// Directed bench for erm16_bus_interface: transaction-age model checked every cycle plus literals.
module tb_erm16_bus_interface;

  localparam int unsigned MW = 1;
  localparam int unsigned TO = 15;
  localparam logic [15:0] ED = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic [15:0] cpu_addr = 16'd0;
  logic [15:0] cpu_do = 16'd0;
  logic        cpu_wrmem = 1'b0;
  logic        cpu_ioe = 1'b0;
  logic [15:0] cpu_di;
  logic        cpu_ready, bus_err;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_re, mem_we;
  logic [15:0] mem_rdata = 16'd0;
  logic [7:0]  io_addr;
  logic [15:0] io_wdata;
  logic        io_rd, io_wr;
  logic [15:0] io_rdata = 16'd0;
  logic        io_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  erm16_bus_interface #(
    .MEM_WAIT  (MW),
    .IO_TIMEOUT(TO),
    .ERR_DATA  (ED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_do    (cpu_do),
    .cpu_wrmem (cpu_wrmem),
    .cpu_ioe   (cpu_ioe),
    .cpu_di    (cpu_di),
    .cpu_ready (cpu_ready),
    .bus_err   (bus_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rd     (io_rd),
    .io_wr     (io_wr),
    .io_rdata  (io_rdata),
    .io_ack    (io_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: tracks one transaction by its age in edges since acceptance.
  logic        m_busy = 0, m_strobe = 0, m_io = 0, m_wr = 0, m_err = 0;
  int          m_age = 0, m_done_at = 0;
  logic [15:0] e_di = 0, e_maddr = 0, e_mwdata = 0, e_iowdata = 0;
  logic [7:0]  e_ioaddr = 0;
  logic        e_ready = 0, e_err = 0;
  logic        started = 0;

  always @(posedge clk) begin
    started = 1;
    e_ready = 0;
    e_err   = 0;
    if (rst) begin
      m_busy = 0; m_strobe = 0; m_err = 0;
      e_di = 0; e_maddr = 0; e_mwdata = 0; e_ioaddr = 0; e_iowdata = 0;
    end else if (!m_busy) begin
      if (cpu_req) begin
        m_busy = 1; m_strobe = 1; m_age = 0;
        m_io = cpu_ioe; m_wr = cpu_wrmem;
        e_maddr = cpu_addr; e_mwdata = cpu_do;
        e_ioaddr = cpu_addr[7:0]; e_iowdata = cpu_do;
      end
    end else begin
      m_age++;
      if (m_strobe) begin
        if (!m_io && m_age == int'(MW) + 1) begin
          m_strobe = 0; m_err = 0; m_done_at = m_age + 1;
          if (!m_wr) e_di = mem_rdata;
        end else if (m_io && io_ack) begin
          m_strobe = 0; m_err = 0; m_done_at = m_age + 1;
          if (!m_wr) e_di = io_rdata;
        end else if (m_io && m_age == int'(TO)) begin
          m_strobe = 0; m_err = 1; m_done_at = m_age + 1;
          if (!m_wr) e_di = ED;
        end
      end else if (m_age == m_done_at) begin
        e_ready = 1; e_err = m_err; m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cpu_di", 32'(cpu_di), 32'(e_di));
      chk("cpu_ready", 32'(cpu_ready), 32'(e_ready));
      chk("bus_err", 32'(bus_err), 32'(e_err));
      chk("mem_re", 32'(mem_re), 32'(m_strobe && !m_io && !m_wr));
      chk("mem_we", 32'(mem_we), 32'(m_strobe && !m_io && m_wr));
      chk("io_rd", 32'(io_rd), 32'(m_strobe && m_io && !m_wr));
      chk("io_wr", 32'(io_wr), 32'(m_strobe && m_io && m_wr));
      chk("mem_addr", 32'(mem_addr), 32'(e_maddr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_mwdata));
      chk("io_addr", 32'(io_addr), 32'(e_ioaddr));
      chk("io_wdata", 32'(io_wdata), 32'(e_iowdata));
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] d, input logic wr,
                       input logic ioe);
    @(posedge clk); #1;
    cpu_req = 1; cpu_addr = a; cpu_do = d; cpu_wrmem = wr; cpu_ioe = ioe;
    @(posedge clk); #1;
    cpu_req = 0;
  endtask

  // i counts negedges after the acceptance edge, starting at 0.
  task automatic wait_done(input int maxc, input int ack_at, input logic [15:0] ack_data,
                           output int lat, output int strobes, output logic err);
    lat = -1; strobes = 0; err = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (i == ack_at) begin
        io_ack = 1; io_rdata = ack_data;
      end else begin
        io_ack = 0;
      end
      if (mem_re | mem_we | io_rd | io_wr) strobes++;
      if (cpu_ready) begin
        lat = i; err = bus_err;
        break;
      end
    end
    io_ack = 0;
  endtask

  initial begin
    int lat, stb, nrdy, last_i;
    logic err;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_di", 32'(cpu_di), 32'd0);
    chk("rst_strobes", 32'({mem_re, mem_we, io_rd, io_wr}), 32'd0);
    rst = 0;

    // 1: memory read
    mem_rdata = 16'h1234;
    issue(16'h0040, 16'h0000, 1'b0, 1'b0);
    wait_done(20, -1, 16'h0, lat, stb, err);
    chk("t1_lat", 32'(lat), 32'd3);
    chk("t1_strobes", 32'(stb), 32'd2);
    chk("t1_di", 32'(cpu_di), 32'h1234);
    chk("t1_addr", 32'(mem_addr), 32'h0040);
    chk("t1_err", 32'(err), 32'd0);

    // 2: memory write keeps cpu_di
    mem_rdata = 16'h5555;
    issue(16'h0007, 16'hBEEF, 1'b1, 1'b0);
    wait_done(20, -1, 16'h0, lat, stb, err);
    chk("t2_lat", 32'(lat), 32'd3);
    chk("t2_strobes", 32'(stb), 32'd2);
    chk("t2_wdata", 32'(mem_wdata), 32'hBEEF);
    chk("t2_di", 32'(cpu_di), 32'h1234);

    // 3: I/O read, ack on third strobe cycle
    issue(16'h0012, 16'h0000, 1'b0, 1'b1);
    wait_done(20, 2, 16'h00A5, lat, stb, err);
    chk("t3_lat", 32'(lat), 32'd4);
    chk("t3_strobes", 32'(stb), 32'd3);
    chk("t3_ioaddr", 32'(io_addr), 32'h12);
    chk("t3_di", 32'(cpu_di), 32'h00A5);
    chk("t3_err", 32'(err), 32'd0);

    // 4: I/O write timeout, then I/O read timeout
    issue(16'h0021, 16'hCAFE, 1'b1, 1'b1);
    wait_done(40, -1, 16'h0, lat, stb, err);
    chk("t4w_lat", 32'(lat), 32'd16);
    chk("t4w_strobes", 32'(stb), 32'd15);
    chk("t4w_err", 32'(err), 32'd1);
    chk("t4w_di", 32'(cpu_di), 32'h00A5);
    issue(16'h0021, 16'h0000, 1'b0, 1'b1);
    wait_done(40, -1, 16'h0, lat, stb, err);
    chk("t4r_lat", 32'(lat), 32'd16);
    chk("t4r_err", 32'(err), 32'd1);
    chk("t4r_di", 32'(cpu_di), 32'hFFFF);

    // 5: cpu_req held high, alternating-address memory reads
    @(posedge clk); #1;
    mem_rdata = 16'h1000;
    cpu_req = 1; cpu_addr = 16'h0200; cpu_wrmem = 0; cpu_ioe = 0;
    nrdy = 0; last_i = 0;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (cpu_ready) begin
        chk("t5_di", 32'(cpu_di), 32'(16'h1000 + 16'(nrdy)));
        chk("t5_gap", 32'(i - last_i), 32'd4);
        last_i = i;
        nrdy++;
        mem_rdata = 16'h1000 + 16'(nrdy);
        cpu_addr = (nrdy % 2 == 1) ? 16'h0300 : 16'h0200;
      end
    end
    cpu_req = 0;
    chk("t5_count", 32'(nrdy), 32'd4);
    repeat (3) @(negedge clk);

    // 6: reset during the second cycle of an I/O read
    issue(16'h0033, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("t6_strobes", 32'({mem_re, mem_we, io_rd, io_wr}), 32'd0);
    chk("t6_ready", 32'(cpu_ready), 32'd0);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("t6_noready", 32'(cpu_ready), 32'd0);
    mem_rdata = 16'h5A5A;
    issue(16'h0100, 16'h0000, 1'b0, 1'b0);
    wait_done(20, -1, 16'h0, lat, stb, err);
    chk("t6_lat", 32'(lat), 32'd3);
    chk("t6_di", 32'(cpu_di), 32'h5A5A);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/erm16_bus_interface.md
Name: erm16_bus_interface

Overview:
- Bus interface unit downstream of the ERM16 core.
- Consumes the core's address (ADDR_BUS), write data (DO), wrmem and ioe.
- Routes each access to either the memory port or the 8-bit-addressed I/O port, inserting wait states.
- Returns read data to the core's DI input and flags completion with a one-cycle ready strobe.
- I/O accesses are ack-based with a timeout that produces a bus error.

Parameters:
MEM_WAIT, 1, memory wait states; memory strobe held MEM_WAIT+1 cycles (range 0..15)
IO_TIMEOUT, 15, maximum cycles to wait for io_ack before a bus error (range 1..255)
ERR_DATA, 16'hFFFF, value returned on cpu_di when an I/O access times out

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
cpu_req  in  1  access request, sampled only in IDLE
cpu_addr  in  16  access address (core ADDR_BUS)
cpu_do  in  16  write data (core DO)
cpu_wrmem  in  1  1=write, 0=read
cpu_ioe  in  1  1=I/O space, 0=memory space
cpu_di  out  16  read data to core, held until the next completion
cpu_ready  out  1  one-cycle completion pulse
bus_err  out  1  one-cycle pulse coincident with cpu_ready on I/O timeout
mem_addr  out  16  memory address
mem_wdata  out  16  memory write data
mem_re  out  1  memory read strobe
mem_we  out  1  memory write strobe
mem_rdata  in  16  memory read data
io_addr  out  8  I/O port number, equal to cpu_addr[7:0]
io_wdata  out  16  I/O write data
io_rd  out  1  I/O read strobe
io_wr  out  1  I/O write strobe
io_rdata  in  16  I/O read data
io_ack  in  1  I/O completion

Behaviour:
- Registered outputs. All outputs are registered.
- Reset values. On rst: state=IDLE; cpu_di=0; cpu_ready=0; bus_err=0; all strobes=0; mem_addr, mem_wdata, io_addr, io_wdata=0.
- Reset mid-access: strobes drop at that same edge. No completion is reported.
- States: IDLE, MEM_ACC, IO_ACC, RESP.
- IDLE:
  - On cpu_req=1, latch cpu_addr, cpu_do and the type.
  - If cpu_ioe=0: go to MEM_ACC, assert mem_re (read) or mem_we (write), load cnt=MEM_WAIT.
  - If cpu_ioe=1: go to IO_ACC, assert io_rd or io_wr, load cnt=IO_TIMEOUT.
- MEM_ACC:
  - If cnt==0: drop the strobe; on a read, capture mem_rdata into cpu_di; go to RESP.
  - Otherwise decrement cnt.
  - mem_re/mem_we are therefore high for exactly MEM_WAIT+1 cycles.
- IO_ACC:
  - If io_ack=1: drop the strobe; on a read, capture io_rdata into cpu_di; go to RESP with err=0.
  - Else if cnt==1: drop the strobe; on a read, load cpu_di=ERR_DATA; go to RESP with err=1.
  - Otherwise decrement cnt.
  - io_ack has priority over timeout in the same cycle.
- RESP:
  - cpu_ready=1 for this cycle only; bus_err=err.
  - Next state is IDLE.
  - cpu_di is unchanged on writes.
- Latency. Counting the request-sampling edge as edge 0, cpu_ready is high in the cycle after edge MEM_WAIT+2.
- Back-to-back requests. cpu_req seen outside IDLE is ignored; there is no queue. The core must hold or re-issue the request, and the next request is accepted at the earliest in the cycle after RESP.
- io_ack seen outside IO_ACC is ignored.
- Address and data outputs hold their latched values from acceptance until the next acceptance.

Decomposition:
- Package erm16_bus_pkg holds:
  - the state enum bus_state_t {IDLE, MEM_ACC, IO_ACC, RESP};
  - the default constants for ERR_DATA, MEM_WAIT and IO_TIMEOUT;
  - the I/O address width constant IO_AW=8.
- One sub-module, bus_wait_timer: 8-bit loadable down-counter with load, dec, value in, count out and a zero flag.
  - It is shared by the memory wait and I/O timeout paths.

Test Plan:
1. Memory read, MEM_WAIT=1, mem_rdata=16'h1234, cpu_req with addr=16'h0040, ioe=0, wrmem=0 -> mem_re high 2 cycles, mem_addr=16'h0040, cpu_ready pulses once, cpu_di=16'h1234, bus_err=0.
2. Memory write addr=16'h0007, cpu_do=16'hBEEF -> mem_we high 2 cycles with mem_wdata=16'hBEEF, cpu_ready pulses, cpu_di keeps its prior value.
3. I/O read port 16'h0012, io_ack asserted on the 3rd strobe cycle with io_rdata=16'h00A5 -> io_addr=8'h12, io_rd high 3 cycles, cpu_di=16'h00A5, bus_err=0.
4. I/O write with io_ack never asserted, IO_TIMEOUT=15 -> io_wr high 15 cycles, then cpu_ready=1 and bus_err=1 in the same cycle. A repeat as a read returns cpu_di=16'hFFFF.
5. cpu_req held high continuously with alternating memory reads -> requests are accepted only in IDLE. With MEM_WAIT=1 there is exactly one cpu_ready every 4 cycles, and no strobe overlap.
6. rst asserted during the 2nd cycle of an I/O read -> strobes and cpu_ready are 0 at the next edge, state is IDLE. A subsequent memory read completes normally with correct data.
